dvs_ravens_aer_rx: RTL and testbench

Parametrised AER receiver that replaces the fixed-size DVS-to-RAVENS front end. It completes the 4-phase REQ/ACK handshake with the DVS camera and pairs Y and X address words into a flattened pixel ID. It formats RAVENS packets and buffers them in a FIFO behind a valid/ready output, so downstream stalls never back-pressure the camera. It sits between the camera pins and the RAVENS packet consumer.

---
 rtl/dvs_ravens_pkg.sv | 24 ++
 rtl/dvs_ravens_aer_rx_if.sv | 37 +++
 rtl/dvs_ravens_fifo.sv | 51 +++++
 rtl/dvs_ravens_aer_rx.sv | 184 ++++++++++++++++++
 tb/tb_dvs_ravens_aer_rx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS-to-RAVENS AER receiver.
// RAVENS packet geometry, sensor defaults, clock period and the Y-word
// settle time (rounded up to whole clocks) live here.
package dvs_ravens_pkg;

    localparam int RAVENS_PKT_BITS = 32;
    localparam int DVS_WIDTH_PXLS  = 128;
    localparam int DVS_HEIGHT_PXLS = 128;
    localparam int CLK_PERIOD_NS   = 10;

    // Y words need the address lines to settle before they are latched.
    localparam int Y_SETTLE_NS   = 50;
    localparam int Y_SETTLE_CYC  = (Y_SETTLE_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int RAVENS_ID_LSB = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LATCH  = 3'd2,
        ACK_HI = 3'd3,
        ACK_LO = 3'd4
    } aer_rx_state_t;

endpackage

// File: rtl/dvs_ravens_aer_rx_if.sv
// Camera-side AER bus plus RAVENS packet output of the receiver.
//
// Handshakes:
//   AER side is a 4-phase REQ/ACK: camera raises req with aer/xsel stable,
//   receiver raises ack, camera drops req, receiver drops ack.
//   Packet side is valid/ready: a packet transfers on every clock edge where
//   pkt_valid && pkt_ready; pkt_valid never depends on pkt_ready, and the
//   head (ravens_pkt) is held stable while pkt_valid is high and unaccepted.
interface dvs_ravens_aer_rx_if #(
    parameter int ADDR_BITS  = 9,
    parameter int FIFO_DEPTH = 8
);
    import dvs_ravens_pkg::*;

    logic [ADDR_BITS:0]             aer;
    logic                           xsel;
    logic                           req;
    logic                           ack;
    logic                           pkt_valid;
    logic                           pkt_ready;
    logic [RAVENS_PKT_BITS-1:0]     ravens_pkt;
    logic [$clog2(FIFO_DEPTH):0]    fifo_level;
    logic [15:0]                    drop_cnt;

    // Camera / consumer side.
    modport master (
        output aer, xsel, req, pkt_ready,
        input  ack, pkt_valid, ravens_pkt, fifo_level, drop_cnt
    );

    // Receiver side.
    modport slave (
        input  aer, xsel, req, pkt_ready,
        output ack, pkt_valid, ravens_pkt, fifo_level, drop_cnt
    );

endinterface

// File: rtl/dvs_ravens_fifo.sv
// Synchronous packet FIFO with full/empty/level status.
// The read port shows the head directly and reads zero when empty, so the
// head only moves on a push into an empty FIFO or on a pop.
// Push and pop in the same cycle are both honoured, even when full.
module dvs_ravens_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks the read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dvs_ravens_aer_rx.sv
// Parametrised AER receiver: completes the 4-phase REQ/ACK handshake with a
// DVS camera, pairs Y and X address words into a flattened pixel ID, and
// queues RAVENS packets in a FIFO so consumer stalls never reach the camera.
// Optional macro DVS_RAVENS_POLARITY_EN: when defined, the X-word polarity
// bit is carried in packet bit RAVENS_ID_LSB-1; otherwise that bit is 0.
module dvs_ravens_aer_rx
    import dvs_ravens_pkg::*;
#(
    parameter int ADDR_BITS       = 9,
    parameter int DVS_WIDTH       = DVS_WIDTH_PXLS,
    parameter int DVS_HEIGHT      = DVS_HEIGHT_PXLS,
    parameter int PIXEL_ID_BITS   = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int Y_SETTLE_CYCLES = Y_SETTLE_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dvs_ravens_aer_rx_if.slave    bus,
    output aer_rx_state_t         dbg_state
);

    localparam int          PROD_BITS  = 2 * ADDR_BITS + 1;
    localparam int          CNT_BITS   = (Y_SETTLE_CYCLES > 1) ? $clog2(Y_SETTLE_CYCLES) : 1;
    localparam int          LVL_BITS   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] WIDTH_LIM  = 32'(DVS_WIDTH);
    localparam logic [31:0] HEIGHT_LIM = 32'(DVS_HEIGHT);

    aer_rx_state_t              state;
    aer_rx_state_t              state_next;
    logic [CNT_BITS-1:0]        cnt;
    logic [CNT_BITS-1:0]        cnt_next;
    logic                       req_meta;
    logic                       req_s;
    logic                       ack_q;
    logic [ADDR_BITS-1:0]       y_reg;
    logic                       y_ok;
    logic                       push_q;
    logic [RAVENS_PKT_BITS-1:0] push_data_q;
    logic [15:0]                drop_cnt_q;

    logic [ADDR_BITS-1:0]       y_word;
    logic [ADDR_BITS-1:0]       x_word;
    logic                       latch_y;
    logic                       latch_x;
    logic                       x_accept;
    logic                       range_drop;
    logic                       full_drop;
    logic [PIXEL_ID_BITS-1:0]   pixel_id;
    logic [RAVENS_PKT_BITS-1:0] pkt_fmt;

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [RAVENS_PKT_BITS-1:0] fifo_rdata;
    logic [LVL_BITS-1:0]        fifo_level;

    // Y word is {pol, y}; X word is {x, pol}.
    assign y_word  = bus.aer[ADDR_BITS-1:0];
    assign x_word  = bus.aer[ADDR_BITS:1];
    assign latch_y = (state == LATCH) && !bus.xsel;
    assign latch_x = (state == LATCH) && bus.xsel;

    // Out-of-range drops are decided at latch time; a full FIFO is judged
    // one cycle later when the registered push actually lands.
    assign x_accept   = y_ok && (32'(x_word) < WIDTH_LIM);
    assign range_drop = latch_x && !x_accept;
    assign fifo_pop   = bus.pkt_ready && !fifo_empty;
    assign full_drop  = push_q && fifo_full && !fifo_pop;
    assign fifo_push  = push_q && !full_drop;

    // Flattened ID: product at 2*ADDR_BITS+1 bits, then truncated.
    assign pixel_id = PIXEL_ID_BITS'(PROD_BITS'(y_reg) * PROD_BITS'(DVS_WIDTH) + PROD_BITS'(x_word));

    // Two-flop synchroniser for the asynchronous camera request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= bus.req;
            req_s    <= req_meta;
        end
    end

    // FSM state, settle counter and registered acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack_q <= (state_next == ACK_HI);
        end
    end

    // Next-state logic; Y words wait out the settle time, X words do not.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_next = SETTLE;
                    cnt_next   = bus.xsel ? '0 : CNT_BITS'(Y_SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (cnt == '0) state_next = LATCH;
                else           cnt_next   = cnt - 1'b1;
            end
            LATCH:   state_next = ACK_HI;
            ACK_HI:  if (!req_s) state_next = ACK_LO;
            ACK_LO:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAVENS packet layout: event type 0, pixel ID, optional polarity.
    always_comb begin
        pkt_fmt = '0;
        pkt_fmt[RAVENS_ID_LSB +: PIXEL_ID_BITS] = pixel_id;
`ifdef DVS_RAVENS_POLARITY_EN
        pkt_fmt[RAVENS_ID_LSB-1] = bus.aer[0];
`else
`endif
    end

    // Y capture; y_reg persists so several X words can share one Y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg <= '0;
            y_ok  <= 1'b0;
        end else if (latch_y) begin
            y_reg <= y_word;
            y_ok  <= (32'(y_word) < HEIGHT_LIM);
        end
    end

    // Register accepted X events one cycle ahead of the FIFO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= latch_x && x_accept;
            if (latch_x) push_data_q <= pkt_fmt;
        end
    end

    // Saturating count of discarded X events (range and full drops never coincide).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if ((range_drop || full_drop) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    dvs_ravens_fifo #(
        .WIDTH (RAVENS_PKT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (push_data_q),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.ack        = ack_q;
    assign bus.pkt_valid  = !fifo_empty;
    assign bus.ravens_pkt = fifo_rdata;
    assign bus.fifo_level = fifo_level;
    assign bus.drop_cnt   = drop_cnt_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_dvs_ravens_aer_rx.sv
// Self-checking bench for dvs_ravens_aer_rx with a 16x32 sensor.
// Stimulus tasks drive 4-phase AER words and push predicted packets into
// exp_q; a monitor pops and compares whenever a packet is transferred.
module tb_dvs_ravens_aer_rx;
    import dvs_ravens_pkg::*;

    localparam int AB   = 9;
    localparam int DW   = 16;
    localparam int DH   = 32;
    localparam int PIB  = 8;
    localparam int FD   = 8;
    localparam int HALF = CLK_PERIOD_NS / 2;
    localparam int Y_LAT_EXP = 4 + (50 + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    aer_rx_state_t dbg_state;

    int            checks = 0;
    int            errors = 0;
    int            ready_mode = 1;   // 0 hold low, 1 hold high, 2 random
    int            model_y = -1;     // last Y word seen, -1 = none since reset
    int            exp_drop = 0;
    logic [31:0]   exp_q[$];

    dvs_ravens_aer_rx_if #(.ADDR_BITS(AB), .FIFO_DEPTH(FD)) bus ();

    dvs_ravens_aer_rx #(
        .ADDR_BITS       (AB),
        .DVS_WIDTH       (DW),
        .DVS_HEIGHT      (DH),
        .PIXEL_ID_BITS   (PIB),
        .FIFO_DEPTH      (FD),
        .Y_SETTLE_CYCLES (Y_SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #HALF clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_pkt(input int y, input int x, input bit pol);
        int id;
        id = (y * DW + x) % (2 ** PIB);
        exp_pkt = 32'(id) << 5;
`ifdef DVS_RAVENS_POLARITY_EN
        if (pol) exp_pkt = exp_pkt | 32'h10;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_ack(input logic val, output int n);
        n = 0;
        while (bus.ack !== val && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.ack !== val) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=%b required=%b", bus.ack, val);
        end
    endtask

    task automatic send_word(input logic xs, input logic [AB:0] word);
        int n;
        @(posedge clk); #1;
        bus.aer  = word;
        bus.xsel = xs;
        bus.req  = 1'b1;
        wait_ack(1'b1, n);
        if (xs) check("x_ack_rise_cycles", 32'(n), 32'd5);
        else begin
            check("y_ack_rise_cycles", 32'(n), 32'(Y_LAT_EXP));
            checks++;
            if (n * CLK_PERIOD_NS < 50) begin
                errors++;
                $display("FAIL y_settle_ns actual=%0d required>=50", n * CLK_PERIOD_NS);
            end
        end
        bus.req = 1'b0;
        wait_ack(1'b0, n);
        check("ack_fall_cycles", 32'(n), 32'd3);
    endtask

    task automatic send_y(input int y);
        model_y = y;
        send_word(1'b0, {1'($urandom_range(0, 1)), 9'(y)});
    endtask

    task automatic send_x(input int x, input bit pol);
        if (model_y < 0 || model_y >= DH || x >= DW || exp_q.size() >= FD) exp_drop++;
        else exp_q.push_back(exp_pkt(model_y, x, pol));
        send_word(1'b1, {9'(x), pol});
        check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
        end
        repeat (3) @(posedge clk);
    endtask

    // Consumer ready, changed just after the active edge.
    initial begin
        bus.pkt_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.pkt_ready = 1'b0;
                1:       bus.pkt_ready = 1'b1;
                default: bus.pkt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.pkt_valid && bus.pkt_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pkt actual=0x%0h required=none", bus.ravens_pkt);
                    end else begin
                        e = exp_q.pop_front();
                        check("pkt", bus.ravens_pkt, e);
                    end
                end else if (!bus.pkt_valid) begin
                    check("empty_pkt_zero", bus.ravens_pkt, 32'h0);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bus.aer  = '0;
        bus.xsel = 1'b0;
        bus.req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check("rst_ravens_pkt", bus.ravens_pkt, 32'd0);
        check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        ready_mode = 1;

        // Dropped events: no Y since reset, Y out of range, X out of range.
        send_x(5, 1'b0);
        send_y(40); send_x(0, 1'b1);
        send_y(3);  send_x(16, 1'b0);
        check("drop_three", 32'(bus.drop_cnt), 32'd3);

        // Directed packets.
        send_y(3);  send_x(10, 1'b1);
        send_y(20); send_x(5, 1'b0);
        send_y(3);  send_x(1, 1'b0); send_x(2, 1'b1); send_x(3, 1'b0);
        wait_drain();

        // Stall: 10 valid events into an 8-deep FIFO.
        ready_mode = 0;
        send_y(1);
        for (int i = 0; i < 10; i++) send_x(i, 1'($urandom_range(0, 1)));
        check("stall_level", 32'(bus.fifo_level), 32'd8);
        check("stall_valid", 32'(bus.pkt_valid), 32'd1);
        ready_mode = 1;
        wait_drain();

        // Randomized words with a randomly stalling consumer.
        ready_mode = 2;
        repeat (150) begin
            if ($urandom_range(0, 9) < 4) send_y($urandom_range(0, 39));
            else send_x($urandom_range(0, 19), 1'($urandom_range(0, 1)));
        end
        ready_mode = 1;
        wait_drain();

        // Reset while ack is high with three packets queued.
        ready_mode = 0;
        send_y(2); send_x(0, 1'b0); send_x(1, 1'b0); send_x(2, 1'b0);
        check("pre_reset_level", 32'(bus.fifo_level), 32'd3);
        @(posedge clk); #1;
        bus.aer  = {1'b0, 9'd5};
        bus.xsel = 1'b0;
        bus.req  = 1'b1;
        wait_ack(1'b1, n);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check("mid_rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
        exp_drop = 0;
        model_y  = 5;   // the still-high request is replayed as a fresh Y word
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ack(1'b1, n);
        check("post_rst_y_rise", 32'(n), 32'(Y_LAT_EXP));
        bus.req = 1'b0;
        wait_ack(1'b0, n);
        check("post_rst_fall", 32'(n), 32'd3);
        ready_mode = 1;
        send_x(4, 1'b0);
        wait_drain();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
